// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types, defaults and address checking for the instruction memory fetch port
package imem_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DATA_W = 32;

  // Error codes are bit masks so both faults can be reported at once.
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_MIS  = 2'b01;
  localparam logic [1:0] ERR_OOR  = 2'b10;

  typedef struct packed {
    logic [IMEM_DATA_W-1:0] data;
    logic [31:0]            addr;
    logic                   err;
  } imem_resp_t;

  // Classify a byte address against a memory of 2**aw words.
  function automatic logic [1:0] imem_err_code(input logic [31:0] addr, input int aw);
    logic [1:0] code;
    code = ERR_NONE;
    if (addr[1:0] != 2'b00) code = code | ERR_MIS;
    if ((addr >> (aw + 2)) != 32'd0) code = code | ERR_OOR;
    return code;
  endfunction

endpackage

// File: rtl/imem_fetch_port_if.sv
// rtl/imem_fetch_port_if.sv - fetch request/response handshake bundle between IF stage and instruction memory
interface imem_fetch_port_if #(
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [31:0]       resp_addr;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_addr, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_data, resp_addr, resp_err
  );

endinterface

// File: rtl/imem_resp_fifo.sv
// rtl/imem_resp_fifo.sv - registered circular response buffer with count and flush
module imem_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 65,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          valid,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head  = store[rd_ptr];
  assign valid = (count != '0);

  // Pointer, count and storage update; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && !valid));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
                                   !(push && !pop && !flush && count == CW'(DEPTH)));

endmodule

// File: rtl/imem_fetch_port.sv
// rtl/imem_fetch_port.sv - instruction memory with buffered valid/ready fetch, debug read and load port; IMEM_FLUSH_EN adds flush
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int    ADDR_W    = IMEM_ADDR_W,
  parameter int    DATA_W    = IMEM_DATA_W,
  parameter int    BUF_DEPTH = 2,
  parameter string INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               rst_n,
  imem_fetch_port_if.slave   fp,
  input  logic [31:0]        show_addr,
  output logic [DATA_W-1:0]  show_data,
  input  logic               ld_we,
  input  logic [31:0]        ld_addr,
  input  logic [DATA_W-1:0]  ld_data
`ifdef IMEM_FLUSH_EN
  ,
  input  logic               flush
`endif
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int EW = DATA_W + 33;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0] req_idx;
  logic              req_bad;
  logic              accept;
  logic              pop;
  logic              flush_i;
  logic              inflight;
  logic [DATA_W-1:0] rd_data;
  logic [31:0]       rd_addr;
  logic              rd_err;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic              unused_addr_bits;

`ifdef IMEM_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign req_idx = fp.req_addr[ADDR_W+1:2];
  assign req_bad = (imem_err_code(fp.req_addr, ADDR_W) != ERR_NONE);
  assign accept  = fp.req_valid && fp.req_ready;
  assign pop     = fp.resp_valid && fp.resp_ready;

  // A pop this cycle frees a slot for a new request now; a flush frees everything.
  assign fp.req_ready = flush_i ||
                        ((int'(count) + int'(inflight) - int'(pop)) < BUF_DEPTH);

  assign show_data = mem[show_addr[ADDR_W+1:2]];

  assign unused_addr_bits = ^{show_addr[31:ADDR_W+2], show_addr[1:0],
                              ld_addr[31:ADDR_W+2], ld_addr[1:0]};

  // Program download writes; a read of the same word at this edge sees the old value.
  always_ff @(posedge clk) begin
    if (ld_we) mem[ld_addr[ADDR_W+1:2]] <= ld_data;
  end

  // Read stage: capture the word for an accepted request, one cycle before it enters the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      rd_data  <= '0;
      rd_addr  <= '0;
      rd_err   <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept) begin
        rd_data <= req_bad ? '0 : mem[req_idx];
        rd_addr <= fp.req_addr;
        rd_err  <= req_bad;
      end
    end
  end

  imem_resp_fifo #(
    .DEPTH (BUF_DEPTH),
    .W     (EW),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_i),
    .push      (inflight),
    .push_data ({rd_data, rd_addr, rd_err}),
    .pop       (pop),
    .head      (head),
    .valid     (fp.resp_valid),
    .count     (count)
  );

  assign {fp.resp_data, fp.resp_addr, fp.resp_err} = head;

endmodule
